// File: rtl/aplic_imsic_msi_tx_pkg.sv
// Shared IMSIC configuration, channel and request types for the APLIC->IMSIC MSI transmitter.
// File-select encoding and the decoded request record live here so both ends agree.
package aplic_imsic_msi_tx_pkg;

  typedef struct packed {
    int NrHarts;
    int NrSources;
    int NrSourcesW;
    int NrVSInptFiles;
    int NrInptFilesW;
  } imsic_cfg_t;

  localparam imsic_cfg_t DefaultImsicCfg = '{
    NrHarts:       4,
    NrSources:     48,
    NrSourcesW:    6,
    NrVSInptFiles: 3,
    NrInptFilesW:  3
  };

  // Hart index field is sized for the user-visible hart space, which may exceed NrHarts.
  localparam int UserNrHartsImsic = 8;
  localparam int MsiHartW = (UserNrHartsImsic > 1) ? $clog2(UserNrHartsImsic) : 1;

  localparam int ChNrHarts = DefaultImsicCfg.NrHarts;
  localparam int ChSrcW    = DefaultImsicCfg.NrSourcesW;
  localparam int ChFileW   = DefaultImsicCfg.NrInptFilesW;

  localparam logic [ChFileW-1:0] M_FILE  = ChFileW'(0);
  localparam logic [ChFileW-1:0] S_FILE  = ChFileW'(1);
  localparam logic [ChFileW-1:0] VS_FILE = ChFileW'(2);

  typedef struct packed {
    logic [ChSrcW-1:0]    setipnum;
    logic [ChNrHarts-1:0] imsic_en;
    logic [ChFileW-1:0]   select_file;
  } aplic_imsic_channel_t;

  typedef struct packed {
    logic [ChSrcW-1:0]   eiid;
    logic [MsiHartW-1:0] hart;
    logic [ChFileW-1:0]  file;
  } aplic_msi_req_t;

  // Guest g of a supervisor-domain target maps onto VS file g-1.
  function automatic logic [ChFileW-1:0] encode_file(input logic mdomain, input logic [5:0] guest);
    logic [6:0]         sum;
    logic [ChFileW-1:0] file;
    sum  = {1'b0, guest} + 7'(VS_FILE) - 7'd1;
    file = sum[ChFileW-1:0];
    if (mdomain) begin
      file = M_FILE;
    end else if (guest == 6'd0) begin
      file = S_FILE;
    end
    return file;
  endfunction

endpackage

// File: rtl/aplic_imsic_msi_tx_if.sv
// Request handshake from the APLIC notifier into the MSI transmitter.
interface aplic_imsic_msi_tx_if
  import aplic_imsic_msi_tx_pkg::*;
#(
  parameter int EiidW = ChSrcW,
  parameter int HartW = MsiHartW
);
  logic             req_valid;
  logic             req_ready;
  logic [EiidW-1:0] req_eiid;
  logic [HartW-1:0] req_hart;
  logic [5:0]       req_guest;
  logic             req_mdomain;

  modport master (
    output req_valid, req_eiid, req_hart, req_guest, req_mdomain,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_eiid, req_hart, req_guest, req_mdomain,
    output req_ready
  );
endinterface

// File: rtl/aplic_msi_fifo.sv
// Generic synchronous FIFO; pointers carry an extra MSB so full and empty differ at wrap.
module aplic_msi_fifo #(
  parameter type T     = logic,
  parameter int  Depth = 4
) (
  input  logic i_clk,
  input  logic ni_rst,
  input  logic i_push,
  input  T     i_data,
  output logic o_full,
  input  logic i_pop,
  output T     o_data,
  output logic o_empty
);
  localparam int AddrW = $clog2(Depth);

  logic [AddrW:0] r_wr_ptr;
  logic [AddrW:0] r_rd_ptr;
  T               r_mem [Depth];
  logic           w_push;
  logic           w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]) &&
                   (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[AddrW-1:0]];

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AddrW-1:0]] <= i_data;
  end
endmodule

// File: rtl/aplic_imsic_msi_tx.sv
// APLIC->IMSIC MSI transmitter: validates notifier requests, buffers decoded entries,
// and emits at most one setipnum beat per cycle with a one-hot hart enable.
module aplic_imsic_msi_tx
  import aplic_imsic_msi_tx_pkg::*;
#(
  parameter imsic_cfg_t ImsicCfg  = DefaultImsicCfg,
  parameter int         FifoDepth = 4,
  parameter int         HartW     = MsiHartW
) (
  input  logic                 i_clk,
  input  logic                 ni_rst,
  aplic_imsic_msi_tx_if.slave  req_if,
  output aplic_imsic_channel_t o_channel,
  output logic                 o_drop,
  output logic [7:0]           o_drop_cnt,
  output logic                 o_busy
);
  logic                 w_full;
  logic                 w_empty;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_invalid;
  logic                 w_push;
  logic                 w_pop;
  logic [HartW-1:0]     w_hart;
  aplic_msi_req_t       w_req;
  aplic_msi_req_t       w_head;
  logic [ChNrHarts-1:0] w_hart_en;

  aplic_imsic_channel_t r_channel;
  logic                 r_drop;
  logic [7:0]           r_drop_cnt;

  // Ready depends only on occupancy and reset, never on the pop decision.
  assign w_ready        = ni_rst && !w_full;
  assign req_if.req_ready = w_ready;
  assign w_accept       = req_if.req_valid && w_ready;
  assign w_hart         = req_if.req_hart;

  assign w_invalid = (req_if.req_eiid == '0) ||
                     (32'(req_if.req_eiid) >= ImsicCfg.NrSources) ||
                     (32'(w_hart) >= ImsicCfg.NrHarts) ||
                     (!req_if.req_mdomain && (32'(req_if.req_guest) > ImsicCfg.NrVSInptFiles));

  assign w_push = w_accept && !w_invalid;
  assign w_pop  = !w_empty;

  always_comb begin
    w_req      = '0;
    w_req.eiid = req_if.req_eiid;
    w_req.hart = MsiHartW'(w_hart);
    w_req.file = encode_file(req_if.req_mdomain, req_if.req_guest);
  end

  aplic_msi_fifo #(
    .T     (aplic_msi_req_t),
    .Depth (FifoDepth)
  ) u_fifo (
    .i_clk   (i_clk),
    .ni_rst  (ni_rst),
    .i_push  (w_push),
    .i_data  (w_req),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty)
  );

  for (genvar gi = 0; gi < ChNrHarts; gi++) begin : g_hart_en
    assign w_hart_en[gi] = (32'(w_head.hart) == gi);
  end

  // Channel fields are all-zero in any cycle without a beat.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      r_channel <= '0;
    end else if (w_pop) begin
      r_channel.setipnum    <= w_head.eiid;
      r_channel.imsic_en    <= w_hart_en;
      r_channel.select_file <= w_head.file;
    end else begin
      r_channel <= '0;
    end
  end

  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      r_drop     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_drop <= w_accept && w_invalid;
      if (w_accept && w_invalid && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign o_channel  = r_channel;
  assign o_drop     = r_drop;
  assign o_drop_cnt = r_drop_cnt;
  assign o_busy     = !w_empty || (r_channel.imsic_en != '0);
endmodule
